// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg                                                             |
// | Shared state encodings and helpers for pipeline stage registers.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package pipe_pkg;

   // Occupancy-coded states: the encoding value is the held-entry count
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam int OCC_W = 2;

   typedef enum logic [1:0] {
      S_EMPTY = EMPTY,
      S_ONE   = ONE,
      S_FULL  = FULL
   } state_e;

   // Number of held entries for a given state
   function automatic logic [OCC_W-1:0] occ_of(input state_e s);
      return logic'(s == S_FULL) ? FULL : (s == S_ONE) ? ONE : EMPTY;
   endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg_if                                                    |
// | Valid/ready handshake bundle around one pipeline stage register.     |
// | master = surrounding pipeline, slave = the stage register itself.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [OCC_W-1:0] occupancy;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg                                                       |
// | Two-entry skid-buffered pipeline register with synchronous flush.    |
// | in_ready depends on registered state only, breaking the ready path.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  wire logic        clk,
   input  wire logic        rst,    // asynchronous, active-low
   pipe_stage_reg_if.slave  bus
);

   state_e           state_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   logic w_in_ready;
   logic w_out_valid;
   logic w_in_xfer;
   logic w_out_xfer;

   // Handshake flags decoded purely from the registered state
   assign w_in_ready  = (state_q != S_FULL);
   assign w_out_valid = (state_q != S_EMPTY);
   assign w_in_xfer   = bus.in_valid  & w_in_ready;
   assign w_out_xfer  = bus.out_ready & w_out_valid;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = main_q;
   assign bus.occupancy = occ_of(state_q);

   // Stage FSM: flush beats every transfer; skid holds the second entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (bus.flush) begin
         state_q <= S_EMPTY;
         if (CLEAR_DATA) begin
            main_q <= '0;
            skid_q <= '0;
         end
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (w_in_xfer) begin
                  main_q  <= bus.in_data;
                  state_q <= S_ONE;
               end
            end
            S_ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  main_q <= bus.in_data;
               end else if (w_in_xfer) begin
                  skid_q  <= bus.in_data;
                  state_q <= S_FULL;
               end else if (w_out_xfer) begin
                  state_q <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (w_out_xfer) begin
                  main_q  <= skid_q;
                  state_q <= S_ONE;
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_reg                                                    |
// | Self-checking bench: queue-based reference model, directed cases     |
// | plus randomized traffic; second instance covers CLEAR_DATA=0.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pipe_stage_reg;

   logic clk;
   logic rst;

   pipe_stage_reg_if #(.WIDTH(32)) bif0 ();
   pipe_stage_reg_if #(.WIDTH(8))  bif1 ();

   pipe_stage_reg #(.WIDTH(32), .CLEAR_DATA(1'b1)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bif0.slave)
   );

   pipe_stage_reg #(.WIDTH(8), .CLEAR_DATA(1'b0)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bif1.slave)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: FIFO of at most two entries, plus a flag saying the
   // main register is known to read zero (after reset/flush, before loads)
   logic [31:0] mq[$];
   bit          zero_main;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare all dut0 outputs with the model's current view
   task automatic check_model(input string tag);
      check_eq({tag, ".occ"},       64'(bif0.occupancy), 64'(mq.size()));
      check_eq({tag, ".in_ready"},  64'(bif0.in_ready),  64'(mq.size() < 2));
      check_eq({tag, ".out_valid"}, 64'(bif0.out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0)
         check_eq({tag, ".out_data"}, 64'(bif0.out_data), 64'(mq[0]));
      else if (zero_main)
         check_eq({tag, ".out_data0"}, 64'(bif0.out_data), 64'd0);
   endtask

   // One clock cycle on dut0, starting and ending just after a falling edge
   task automatic cycle(input string tag, input bit v, input logic [31:0] d,
                        input bit r, input bit f);
      int pre;
      bif0.in_valid  = v;
      bif0.in_data   = d;
      bif0.out_ready = r;
      bif0.flush     = f;
      #1;
      check_model(tag);
      pre = mq.size();
      @(posedge clk);
      if (f) begin
         mq.delete();
         zero_main = 1'b1;
      end else begin
         if (r && pre > 0) void'(mq.pop_front());
         if (v && pre < 2) begin
            mq.push_back(d);
            zero_main = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst            = 1'b0;
      bif0.flush     = 1'b0;
      bif0.in_valid  = 1'b0;
      bif0.in_data   = '0;
      bif0.out_ready = 1'b0;
      bif1.flush     = 1'b0;
      bif1.in_valid  = 1'b0;
      bif1.in_data   = '0;
      bif1.out_ready = 1'b0;
      zero_main      = 1'b1;

      // Reset values while held in reset
      @(negedge clk);
      #1;
      check_eq("rst.occ",       64'(bif0.occupancy), 64'd0);
      check_eq("rst.in_ready",  64'(bif0.in_ready),  64'd1);
      check_eq("rst.out_valid", 64'(bif0.out_valid), 64'd0);
      check_eq("rst.out_data",  64'(bif0.out_data),  64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Single push: visible one cycle later
      cycle("a5", 1'b1, 32'hA5, 1'b1, 1'b0);
      #1;
      check_eq("a5.out_valid", 64'(bif0.out_valid), 64'd1);
      check_eq("a5.out_data",  64'(bif0.out_data),  64'hA5);
      check_eq("a5.occ",       64'(bif0.occupancy), 64'd1);
      cycle("drain0", 1'b0, 32'h0, 1'b1, 1'b0);

      // Fill to FULL with a stalled consumer, third push refused
      cycle("p11", 1'b1, 32'h11, 1'b0, 1'b0);
      cycle("p22", 1'b1, 32'h22, 1'b0, 1'b0);
      #1;
      check_eq("full.occ",      64'(bif0.occupancy), 64'd2);
      check_eq("full.in_ready", 64'(bif0.in_ready),  64'd0);
      cycle("p33", 1'b1, 32'h33, 1'b0, 1'b0);
      cycle("pop11", 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check_eq("pop.second", 64'(bif0.out_data), 64'h22);
      cycle("pop22", 1'b0, 32'h0, 1'b1, 1'b0);
      cycle("idle", 1'b0, 32'h0, 1'b1, 1'b0);

      // Streaming 1..100 at full rate
      for (int k = 1; k <= 100; k++)
         cycle("stream", 1'b1, 32'(k), 1'b1, 1'b0);
      cycle("stream.tail", 1'b0, 32'h0, 1'b1, 1'b0);

      // Flush from FULL with a simultaneous push
      cycle("f11", 1'b1, 32'h11, 1'b0, 1'b0);
      cycle("f22", 1'b1, 32'h22, 1'b0, 1'b0);
      cycle("flush", 1'b1, 32'h44, 1'b0, 1'b1);
      #1;
      check_eq("flush.occ",       64'(bif0.occupancy), 64'd0);
      check_eq("flush.out_valid", 64'(bif0.out_valid), 64'd0);
      check_eq("flush.out_data",  64'(bif0.out_data),  64'd0);
      cycle("flush.after", 1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges while FULL
      cycle("r1", 1'b1, 32'h1234, 1'b0, 1'b0);
      cycle("r2", 1'b1, 32'h5678, 1'b0, 1'b0);
      bif0.in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_eq("arst.occ",       64'(bif0.occupancy), 64'd0);
      check_eq("arst.out_valid", 64'(bif0.out_valid), 64'd0);
      check_eq("arst.in_ready",  64'(bif0.in_ready),  64'd1);
      check_eq("arst.out_data",  64'(bif0.out_data),  64'd0);
      mq.delete();
      zero_main = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cycle("p7", 1'b1, 32'h7, 1'b1, 1'b0);
      #1;
      check_eq("p7.out_data", 64'(bif0.out_data), 64'h7);
      cycle("p7.drain", 1'b0, 32'h0, 1'b1, 1'b0);

      // Randomized traffic with occasional flushes
      for (int k = 0; k < 400; k++)
         cycle("rand", 1'($urandom_range(0, 1)), 32'($urandom),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      cycle("rand.end", 1'b0, 32'h0, 1'b1, 1'b0);

      // CLEAR_DATA=0, WIDTH=8 instance: flush in ONE then push 0xFF
      bif1.in_valid = 1'b1;
      bif1.in_data  = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      bif1.in_valid = 1'b0;
      #1;
      check_eq("nc.one.valid", 64'(bif1.out_valid), 64'd1);
      check_eq("nc.one.data",  64'(bif1.out_data),  64'h5A);
      bif1.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bif1.flush = 1'b0;
      #1;
      check_eq("nc.flush.valid", 64'(bif1.out_valid), 64'd0);
      check_eq("nc.flush.occ",   64'(bif1.occupancy), 64'd0);
      bif1.in_valid = 1'b1;
      bif1.in_data  = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      bif1.in_valid = 1'b0;
      #1;
      check_eq("nc.ff.valid", 64'(bif1.out_valid), 64'd1);
      check_eq("nc.ff.data",  64'(bif1.out_data),  64'hFF);
      bif1.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("nc.drain.valid", 64'(bif1.out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter CLEAR_DATA, default 1: 1 zeroes payload registers on flush; 0 clears valid state only.
REQ-003 Port clk  input  1: single clock, all state on rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset (asserted when 0).
REQ-005 Port flush  input  1: synchronous squash of all held entries (branch/hazard kill).
REQ-006 Port in_valid  input  1: upstream offers in_data this cycle.
REQ-007 Port in_ready  output  1: stage accepts in_data this cycle.
REQ-008 Port in_data  input  WIDTH: upstream payload (packed control + operands).
REQ-009 Port out_valid  output  1: out_data holds a live entry.
REQ-010 Port out_ready  input  1: downstream accepts out_data this cycle.
REQ-011 Port out_data  output  WIDTH: payload presented to the next stage.
REQ-012 Port occupancy  output  2: number of held entries, 0..2.

Function
REQ-013 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-014 Storage consists of a main register (drives out_data) and one skid register; the state is EMPTY (0), ONE (1) or FULL (2), and occupancy equals that count.
REQ-015 in_ready is 1 in EMPTY and ONE and 0 in FULL; it is decoded from registered state only, with no combinational path from out_ready.
REQ-016 out_valid is 1 in ONE and FULL; out_data always equals the main register.
REQ-017 EMPTY: an input transfer loads main and moves to ONE; otherwise the state holds.
REQ-018 ONE: input and output transfer together load main with in_data and hold ONE; input transfer alone loads skid and moves to FULL; output transfer alone moves to EMPTY.
REQ-019 FULL: an output transfer copies skid into main and moves to ONE; otherwise the state holds with no register change.
REQ-020 Latency is 1 cycle from input transfer to out_valid when EMPTY; sustained throughput is 1 transfer per cycle while out_ready=1.
REQ-021 Payload order is strictly FIFO; no entry is duplicated or dropped except by flush.
REQ-022 flush=1 takes priority over all transfers: the next state is EMPTY, and an input transfer in that cycle is discarded.
REQ-023 An output transfer in a flush cycle counts as delivered, because out_valid and out_data are registered and unchanged within that cycle.
REQ-024 With CLEAR_DATA=1, flush also zeroes main and skid; with CLEAR_DATA=0, their contents are unspecified but out_valid=0.
REQ-025 In EMPTY, out_data is don't-care for correctness; with CLEAR_DATA=1 it reads 0 after reset or flush.

Reset
REQ-026 While rst=0, asynchronously: state=EMPTY, main=0, skid=0, out_valid=0, occupancy=0, in_ready=1.
REQ-027 Reset asserted mid-transfer discards all held entries; the first rising clk edge with rst=1 behaves as in EMPTY.

Structure
REQ-028 State encodings EMPTY/ONE/FULL are localparams in the shared package pipe_pkg, and all stage-register instances use this package.
REQ-029 The block is a single module with no sub-module; each existing ID/EX-style stage register becomes one instance with WIDTH equal to its packed field width.

Verification
REQ-030 Reset, then in_valid=1 with data 0xA5 and out_ready=1 -> out_valid=1 and out_data=0xA5 the next cycle; occupancy=1.
REQ-031 out_ready=0 and push 0x11, then 0x22 -> occupancy=2 and in_ready=0; a third push 0x33 is not accepted; with out_ready=1, 0x11 then 0x22 emerge on consecutive cycles.
REQ-032 Continuous in_valid=1 and out_ready=1 with data 1..100 -> 100 outputs in order at 1 per cycle; in_ready stays 1 throughout.
REQ-033 FULL with 0x11/0x22, then flush=1 together with in_valid=1 (0x44) -> next cycle occupancy=0, out_valid=0, out_data=0 (CLEAR_DATA=1); 0x44 never appears.
REQ-034 rst driven low between clock edges while occupancy=2 -> outputs reach reset values immediately without a clock edge; after release, push 0x7 -> 0x7 appears 1 cycle later.
REQ-035 CLEAR_DATA=0 and WIDTH=8: flush in ONE -> out_valid=0 next cycle; the following push 0xFF is delivered intact.
